// File: rtl/uart_tx.sv
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 UART transmitter fed by a power-of-two byte FIFO.
//                Frames are sent back-to-back while bytes remain queued.
//                Optional macro UART_TX_PARITY_EN inserts an even-parity bit
//                between the last data bit and the stop bit (8E1 framing).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int CLKS_PER_BIT = 187,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          tx_clear,
  input  logic [7:0]                    tx_DI,
  input  logic                          tx_wr,
  output logic                          tx_full,
  output logic                          tx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic                          tx_busy,
  output logic                          uart_port_DO
);

  localparam int                   c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam logic [15:0]          c_bit_max = 16'(CLKS_PER_BIT - 1);
  localparam logic [c_ptr_w:0]     c_depth   = (c_ptr_w + 1)'(FIFO_DEPTH);
  localparam logic [c_ptr_w:0]     c_cnt_one = (c_ptr_w + 1)'(1);
  localparam logic [c_ptr_w-1:0]   c_ptr_one = c_ptr_w'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t             r_state;
  logic [15:0]        r_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_do;
  logic               r_busy;
`ifdef UART_TX_PARITY_EN
  logic               r_parity;
`endif

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic [7:0]         w_head;

  assign tx_count     = r_count;
  assign tx_empty     = (r_count == '0);
  assign tx_full      = (r_count == c_depth);
  assign tx_busy      = r_busy;
  assign uart_port_DO = r_do;

  assign w_head = r_mem[r_rd_ptr];
  // Writes against a full FIFO are dropped even if a pop frees a slot on the same edge.
  assign w_push = tx_wr && !tx_full && !tx_clear;
  // The FSM fetches the next byte from IDLE or at the very end of a stop bit.
  assign w_pop  = !tx_clear && !tx_empty &&
                  ((r_state == IDLE) || ((r_state == STOP) && (r_cnt == '0)));

  // FIFO storage; contents need no reset because the count gates all reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_DI;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (tx_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame sequencer with registered serial line and busy flag.
  always_ff @(posedge clk) begin
    if (tx_clear) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_do      <= 1'b1;
      r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^w_head;
`endif
            r_state  <= START;
            r_cnt    <= c_bit_max;
            r_do     <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        START: begin
          if (r_cnt == '0) begin
            r_state   <= DATA;
            r_cnt     <= c_bit_max;
            r_bit_idx <= '0;
            r_do      <= r_shift[0];
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        DATA: begin
          if (r_cnt == '0) begin
            r_cnt <= c_bit_max;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
              r_do    <= r_parity;
`else
              r_state <= STOP;
              r_do    <= 1'b1;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_do      <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (r_cnt == '0) begin
            r_state <= STOP;
            r_cnt   <= c_bit_max;
            r_do    <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`endif
        STOP: begin
          if (r_cnt == '0) begin
            if (w_pop) begin
              // Chain straight into the next frame without an idle gap.
              r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
              r_parity <= ^w_head;
`endif
              r_state  <= START;
              r_cnt    <= c_bit_max;
              r_do     <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_do    <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_do    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx (CLKS_PER_BIT=4, depth 4).
//                Expected bytes go into a scoreboard queue as they are written;
//                a serial-line monitor decodes frames and pops/compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  localparam int C = 4;
  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * C;

  logic             clk = 1'b0;
  logic             tx_clear = 1'b1;
  logic [7:0]       tx_DI = 8'h00;
  logic             tx_wr = 1'b0;
  logic             tx_full;
  logic             tx_empty;
  logic [$clog2(D):0] tx_count;
  logic             tx_busy;
  logic             uart_port_DO;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int frames_seen = 0;
  logic [7:0] sb[$];

  uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk          (clk),
    .tx_clear     (tx_clear),
    .tx_DI        (tx_DI),
    .tx_wr        (tx_wr),
    .tx_full      (tx_full),
    .tx_empty     (tx_empty),
    .tx_count     (tx_count),
    .tx_busy      (tx_busy),
    .uart_port_DO (uart_port_DO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One write strobe; the bench states whether the byte should be accepted.
  task automatic wr(input logic [7:0] b, input bit acc);
    tx_DI = b;
    tx_wr = 1'b1;
    if (acc) sb.push_back(b);
    step();
    tx_wr = 1'b0;
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (tx_busy === 1'b1 && n < 500) begin
      n++;
      step();
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (!(tx_busy === 1'b0 && tx_empty === 1'b1) && k < 2000) begin
      k++;
      step();
    end
    chk(tag, (k >= 2000) ? 32'd1 : 32'd0, 32'd0);
    repeat (3) step();
  endtask

  task automatic wait_cyc(input int target);
    int k;
    k = 0;
    while (cyc < target && k < 2000) begin
      k++;
      step();
    end
  endtask

  // Decode one frame whose first start-bit sample was just taken.
  task automatic mon_frame();
    logic [7:0] data;
    logic       ok;
    logic       par;
    logic [7:0] exp;
    ok   = 1'b1;
    data = 8'h00;
    par  = 1'b0;
    for (int k = 1; k < C; k++) begin
      @(negedge clk);
      if (tx_clear) return;
      if (uart_port_DO !== 1'b0) ok = 1'b0;
    end
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < C; k++) begin
        @(negedge clk);
        if (tx_clear) return;
        if (k == 0) data[b] = uart_port_DO;
        else if (uart_port_DO !== data[b]) ok = 1'b0;
      end
    end
`ifdef UART_TX_PARITY_EN
    for (int k = 0; k < C; k++) begin
      @(negedge clk);
      if (tx_clear) return;
      if (k == 0) par = uart_port_DO;
      else if (uart_port_DO !== par) ok = 1'b0;
    end
`endif
    for (int k = 0; k < C; k++) begin
      @(negedge clk);
      if (tx_clear) return;
      if (uart_port_DO !== 1'b1) ok = 1'b0;
    end
    frames_seen++;
    chk("bit_timing", {31'd0, ok}, 32'd1);
    chk("sb_nonempty", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      chk("frame_data", {24'd0, data}, {24'd0, exp});
`ifdef UART_TX_PARITY_EN
      chk("parity_bit", {31'd0, par}, {31'd0, ^exp});
`endif
    end
  endtask

  // Serial-line monitor: a low sample outside reset marks a start bit.
  initial begin
    forever begin
      @(negedge clk);
      if (uart_port_DO === 1'b0 && tx_clear === 1'b0) mon_frame();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int s;
    int fb;

    // Reset state.
    repeat (3) step();
    chk("rst_do", {31'd0, uart_port_DO}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_count", {29'd0, tx_count}, 32'd0);
    chk("rst_empty", {31'd0, tx_empty}, 32'd1);
    chk("rst_full", {31'd0, tx_full}, 32'd0);
    tx_clear = 1'b0;
    step();

    // Single byte from idle: line falls on the edge after the accepting edge.
    wr(8'h41, 1'b1);
    chk("t1_count_after_wr", {29'd0, tx_count}, 32'd1);
    chk("t1_do_still_high", {31'd0, uart_port_DO}, 32'd1);
    step();
    chk("t1_do_start", {31'd0, uart_port_DO}, 32'd0);
    chk("t1_busy", {31'd0, tx_busy}, 32'd1);
    chk("t1_count_popped", {29'd0, tx_count}, 32'd0);
    measure_busy(n);
    chk("t1_busy_cycles", n, FRAME);
    chk("t1_empty", {31'd0, tx_empty}, 32'd1);
    chk("t1_do_idle", {31'd0, uart_port_DO}, 32'd1);
    repeat (3) step();

    // Two consecutive writes: back-to-back frames with push+pop netting zero.
    tx_DI = 8'h41;
    tx_wr = 1'b1;
    sb.push_back(8'h41);
    step();
    chk("t2_count_e0", {29'd0, tx_count}, 32'd1);
    tx_DI = 8'h42;
    sb.push_back(8'h42);
    step();
    tx_wr = 1'b0;
    chk("t2_count_e1", {29'd0, tx_count}, 32'd1);
    chk("t2_do_start", {31'd0, uart_port_DO}, 32'd0);
    measure_busy(n);
    chk("t2_busy_cycles", n, 2 * FRAME);
    chk("t2_count_end", {29'd0, tx_count}, 32'd0);
    wait_idle("t2_idle_timeout");

    // Overfill while a frame is on the line; then a dropped write on a pop edge.
    wr(8'h10, 1'b1);
    step();
    s = cyc;
    wr(8'h11, 1'b1);
    wr(8'h12, 1'b1);
    wr(8'h13, 1'b1);
    wr(8'h14, 1'b1);
    wr(8'h15, 1'b0);
    wr(8'h16, 1'b0);
    chk("t3_full", {31'd0, tx_full}, 32'd1);
    chk("t3_count_full", {29'd0, tx_count}, 32'd4);
    wait_cyc(s + FRAME - 1);
    chk("t3_pre_pop_count", {29'd0, tx_count}, 32'd4);
    wr(8'h77, 1'b0);
    chk("t3_pop_drop_count", {29'd0, tx_count}, 32'd3);
    chk("t3_pop_drop_full", {31'd0, tx_full}, 32'd0);
    chk("t3_chained_start", {31'd0, uart_port_DO}, 32'd0);
    wait_idle("t3_idle_timeout");

    // Clear during data bit 3 with two bytes queued.
    wr(8'h55, 1'b1);
    step();
    s = cyc;
    wr(8'hA0, 1'b1);
    wr(8'hA1, 1'b1);
    chk("t4_count_queued", {29'd0, tx_count}, 32'd2);
    wait_cyc(s + 16);
    tx_clear = 1'b1;
    tx_DI = 8'h99;
    tx_wr = 1'b1;
    sb.delete();
    step();
    tx_clear = 1'b0;
    tx_wr = 1'b0;
    chk("t4_do_high", {31'd0, uart_port_DO}, 32'd1);
    chk("t4_count_zero", {29'd0, tx_count}, 32'd0);
    chk("t4_busy_low", {31'd0, tx_busy}, 32'd0);
    chk("t4_empty", {31'd0, tx_empty}, 32'd1);
    fb = frames_seen;
    repeat (60) step();
    chk("t4_no_frames", frames_seen, fb);
    chk("t4_do_still_high", {31'd0, uart_port_DO}, 32'd1);
    chk("t4_count_still_zero", {29'd0, tx_count}, 32'd0);

    // A byte with odd population (parity 1 when parity is enabled).
    wr(8'h43, 1'b1);
    step();
    measure_busy(n);
    chk("t5_busy_cycles", n, FRAME);
    wait_idle("t5_idle_timeout");

    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 187, meaning clk cycles per serial bit (21.55 MHz clk / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning transmit FIFO entries; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port tx_clear  input  1  synchronous active-high reset.
REQ-005 SHALL have port tx_DI  input  8  byte to enqueue.
REQ-006 SHALL have port tx_wr  input  1  enqueue strobe, one byte per high cycle.
REQ-007 SHALL have port tx_full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-008 SHALL have port tx_empty  output  1  FIFO holds zero bytes.
REQ-009 SHALL have port tx_count  output  clog2(FIFO_DEPTH)+1  bytes currently queued.
REQ-010 SHALL have port tx_busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port uart_port_DO  output  1  serial line, idle high.

Function
REQ-012 SHALL accept tx_DI into the FIFO tail on any cycle with tx_wr=1 and tx_full=0; tx_count increments on the following edge.
REQ-013 SHALL ignore tx_wr while tx_full=1; the byte is dropped and FIFO contents are unchanged, including on a cycle in which the FIFO also pops.
REQ-014 SHALL apply a simultaneous accepted write and pop as a net tx_count change of zero.
REQ-015 SHALL implement the states IDLE, START, DATA, STOP (plus PARITY, see REQ-026), all registered, with a CLKS_PER_BIT down-counter and a 3-bit bit index.
REQ-016 SHALL, on the edge where the state is IDLE and tx_empty=0: pop the FIFO head into an 8-bit shift register, enter START, and drive uart_port_DO=0 from that edge.
REQ-017 SHALL hold each of the start, data, parity, and stop bits on uart_port_DO for exactly CLKS_PER_BIT clk cycles.
REQ-018 SHALL send data bits LSB first (bit 0 through bit 7), then one stop bit at 1.
REQ-019 SHALL, at the end of STOP, enter START directly, with no idle gap and the pop performed on the same edge, when tx_empty=0; otherwise it SHALL enter IDLE.
REQ-020 SHALL cause a first frame to start on the edge after the accepting write edge, i.e. uart_port_DO falls 2 edges after tx_wr is sampled, when the block is in IDLE with an empty FIFO.
REQ-021 SHALL keep the 8 data bits of a frame in progress unchanged regardless of FIFO writes.
REQ-022 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; tx_full/tx_empty SHALL be derived from tx_count.

Reset
REQ-023 SHALL, on any edge with tx_clear=1, force state IDLE, uart_port_DO=1, tx_busy=0, tx_count=0, tx_empty=1, tx_full=0, and pointers and counters to 0.
REQ-024 SHALL abort a frame in progress when tx_clear=1 mid-frame (line high on that same edge) and discard all queued bytes; no partial frame resumes.
REQ-025 SHALL ignore tx_wr while tx_clear=1.

Configuration
REQ-026 SHALL, when macro UART_TX_PARITY_EN is defined, insert a PARITY state between DATA and STOP that sends the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving a frame of 11*CLKS_PER_BIT cycles.
REQ-027 SHALL, when UART_TX_PARITY_EN is undefined, omit PARITY entirely (no state encoding, no logic), giving a frame of 10*CLKS_PER_BIT cycles.

Verification
REQ-028 SHALL cover: CLKS_PER_BIT=4, write 0x41 once from idle -> DO low 2 edges after write, then bit sequence 0,1,0,0,0,0,0,1,0,1 each 4 cycles wide, tx_busy high 40 cycles, then tx_empty=1.
REQ-029 SHALL cover: write 0x41, 0x42 on consecutive cycles -> two frames back-to-back, 80 cycles total with no high gap between the first stop bit and the second start bit; tx_count sequence 1,1,0 around the first pop.
REQ-030 SHALL cover: FIFO_DEPTH=4, write 6 bytes while a frame is in progress -> 4 accepted, tx_full=1, bytes 5 and 6 dropped, and the serial output carries exactly the first frame plus 4 queued bytes in order.
REQ-031 SHALL cover: tx_clear pulsed for 1 cycle during data bit 3 with 2 bytes queued -> DO=1 on the next edge, tx_count=0, no further frames.
REQ-032 SHALL cover: UART_TX_PARITY_EN defined, send 0x41 and 0x43 -> parity bits 0 and 1 respectively, 44 cycles per frame at CLKS_PER_BIT=4.
REQ-033 SHALL cover: a write on the same cycle as a pop with tx_full=1 -> write dropped, tx_count decrements by 1.
